traffic_light_monitor: RTL and testbench

- Passive checker sitting on the red/yellow/green outputs of the traffic light controller; it is the observing end of that light interface.
- Samples the three lights every clock and tracks the current phase and its dwell time.
- Flags illegal encodings, illegal phase order and wrong phase durations with sticky error bits.
- Counts fully clean R->G->Y cycles; used both in-system as a safety monitor and in benches as a scoreboard.

---
 rtl/traffic_light_monitor.sv | 164 ++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker for a red/yellow/green light interface: tracks phase and dwell,
// raises sticky encoding/order/duration errors and counts clean R->G->Y cycles.
module traffic_light_monitor #(
  parameter int unsigned RED_CYCLES    = 6,
  parameter int unsigned GREEN_CYCLES  = 6,
  parameter int unsigned YELLOW_CYCLES = 3,
  parameter int unsigned DWELL_W       = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clear,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] cycle_count,
  output logic             err_onehot,
  output logic             err_order,
  output logic             err_duration,
  output logic             error
);

  typedef enum logic [1:0] {
    PH_RED    = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_RESYNC = 2'b11
  } phase_e;

  localparam logic [DWELL_W-1:0] RED_REQ    = DWELL_W'(RED_CYCLES);
  localparam logic [DWELL_W-1:0] GREEN_REQ  = DWELL_W'(GREEN_CYCLES);
  localparam logic [DWELL_W-1:0] YELLOW_REQ = DWELL_W'(YELLOW_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_MAX  = '1;
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  phase_e             phase_q, phase_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               clean_q, clean_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               onehot_q, onehot_d;
  logic               order_q, order_d;
  logic               dur_q, dur_d;
  logic               error_q, error_d;

  phase_e             s_phase;
  logic               s_valid;
  phase_e             succ_phase;
  logic [DWELL_W-1:0] req_dwell;
  logic               onehot_set, order_set, dur_set, cnt_inc;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    s_phase = PH_RESYNC;
    s_valid = 1'b0;
    case ({red, yellow, green})
      3'b100:  begin s_phase = PH_RED;    s_valid = 1'b1; end
      3'b010:  begin s_phase = PH_YELLOW; s_valid = 1'b1; end
      3'b001:  begin s_phase = PH_GREEN;  s_valid = 1'b1; end
      default: ;
    endcase

    req_dwell  = '0;
    succ_phase = PH_RESYNC;
    case (phase_q)
      PH_RED:    begin req_dwell = RED_REQ;    succ_phase = PH_GREEN;  end
      PH_GREEN:  begin req_dwell = GREEN_REQ;  succ_phase = PH_YELLOW; end
      PH_YELLOW: begin req_dwell = YELLOW_REQ; succ_phase = PH_RED;    end
      default:   ;
    endcase
  end

  always_comb begin
    phase_d    = phase_q;
    dwell_d    = dwell_q;
    clean_d    = clean_q;
    onehot_set = 1'b0;
    order_set  = 1'b0;
    dur_set    = 1'b0;
    cnt_inc    = 1'b0;

    if (!s_valid) begin
      onehot_set = 1'b1;
      clean_d    = 1'b0;
      phase_d    = PH_RESYNC;
      dwell_d    = '0;
    end else if (phase_q == PH_RESYNC) begin
      // Only a red sample re-enters the checked sequence; it starts a fresh cycle.
      if (s_phase == PH_RED) begin
        phase_d = PH_RED;
        dwell_d = DWELL_W'(1);
        clean_d = 1'b1;
      end
    end else if (s_phase == phase_q) begin
      dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DWELL_W'(1);
      if (dwell_q == req_dwell) begin
        dur_set = 1'b1;
        clean_d = 1'b0;
      end
    end else if (s_phase == succ_phase) begin
      if (dwell_q != req_dwell) begin
        dur_set = 1'b1;
        clean_d = 1'b0;
      end
      phase_d = s_phase;
      dwell_d = DWELL_W'(1);
      if (phase_q == PH_YELLOW) begin
        cnt_inc = clean_q && (dwell_q == req_dwell);
        clean_d = 1'b1;
      end
    end else begin
      // Out-of-order jump: the abandoned phase gets no duration check.
      order_set = 1'b1;
      clean_d   = 1'b0;
      phase_d   = s_phase;
      dwell_d   = DWELL_W'(1);
    end

    if (clear) begin
      onehot_d = onehot_set;
      order_d  = order_set;
      dur_d    = dur_set;
      cnt_d    = '0;
    end else begin
      onehot_d = onehot_q | onehot_set;
      order_d  = order_q  | order_set;
      dur_d    = dur_q    | dur_set;
      cnt_d    = (cnt_inc && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    error_d = onehot_d | order_d | dur_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= PH_RED;
      dwell_q  <= '0;
      clean_q  <= 1'b1;
      cnt_q    <= '0;
      onehot_q <= 1'b0;
      order_q  <= 1'b0;
      dur_q    <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      dwell_q  <= dwell_d;
      clean_q  <= clean_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      order_q  <= order_d;
      dur_q    <= dur_d;
      error_q  <= error_d;
    end
  end

  assign phase        = phase_q;
  assign cycle_count  = cnt_q;
  assign err_onehot   = onehot_q;
  assign err_order    = order_q;
  assign err_duration = dur_q;
  assign error        = error_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor; a second instance with CNT_W=2
// shares the stimulus to exercise cycle counter saturation.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       reset, red, yellow, green, clear;
  logic [1:0] phase;
  logic [7:0] cycle_count;
  logic       err_onehot, err_order, err_duration, error;
  logic [1:0] phase2;
  logic [1:0] cycle_count2;
  logic       err_onehot2, err_order2, err_duration2, error2;
  logic [5:0] st, st2;

  int tests_run    = 0;
  int tests_failed = 0;

  assign st  = {phase, err_onehot, err_order, err_duration, error};
  assign st2 = {phase2, err_onehot2, err_order2, err_duration2, error2};

  traffic_light_monitor dut (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green), .clear(clear),
    .phase(phase), .cycle_count(cycle_count), .err_onehot(err_onehot),
    .err_order(err_order), .err_duration(err_duration), .error(error)
  );

  traffic_light_monitor #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green), .clear(clear),
    .phase(phase2), .cycle_count(cycle_count2), .err_onehot(err_onehot2),
    .err_order(err_order2), .err_duration(err_duration2), .error(error2)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge and are sampled on the next one.
  task automatic apply(input logic [2:0] ryg, input int n, input logic clr);
    for (int i = 0; i < n; i++) begin
      {red, yellow, green} = ryg;
      clear = clr;
      @(posedge clk);
      #1;
    end
    clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {red, yellow, green} = 3'b000;
    clear = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {red, yellow, green} = 3'b000;
    clear = 1'b0;
    #2;
    tests_run++;
    if (st !== 6'b00_0000 || cycle_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_state: st=%b cnt=%0d expected st=000000 cnt=0", st, cycle_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_clean_cycles();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply(R, 6, 1'b0);
      tests_run++;
      if (st !== 6'b00_0000) begin
        tests_failed++;
        $display("FAIL clean_red[%0d]: st=%b expected 000000", c, st);
      end
      apply(G, 6, 1'b0);
      tests_run++;
      if (st !== 6'b01_0000) begin
        tests_failed++;
        $display("FAIL clean_green[%0d]: st=%b expected 010000", c, st);
      end
      apply(Y, 3, 1'b0);
      tests_run++;
      if (st !== 6'b10_0000 || cycle_count !== 8'(c)) begin
        tests_failed++;
        $display("FAIL clean_yellow[%0d]: st=%b cnt=%0d expected st=100000 cnt=%0d", c, st, cycle_count, c);
      end
    end
    apply(R, 1, 1'b0);
    tests_run++;
    if (st !== 6'b00_0000 || cycle_count !== 8'd3) begin
      tests_failed++;
      $display("FAIL clean_count: st=%b cnt=%0d expected st=000000 cnt=3", st, cycle_count);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    apply(R, 6, 1'b0);
    tests_run++;
    if (st !== 6'b00_0000) begin
      tests_failed++;
      $display("FAIL overrun_pre: st=%b expected 000000", st);
    end
    apply(R, 1, 1'b0);
    tests_run++;
    if (st !== 6'b00_0011) begin
      tests_failed++;
      $display("FAIL overrun_edge: st=%b expected 000011", st);
    end
    apply(G, 6, 1'b0);
    apply(Y, 3, 1'b0);
    apply(R, 1, 1'b0);
    tests_run++;
    if (st !== 6'b00_0011 || cycle_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL overrun_nocount: st=%b cnt=%0d expected st=000011 cnt=0", st, cycle_count);
    end
    apply(R, 5, 1'b0);
    apply(G, 6, 1'b0);
    apply(Y, 3, 1'b0);
    apply(R, 1, 1'b0);
    tests_run++;
    if (cycle_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL overrun_recover: cnt=%0d expected 1", cycle_count);
    end
  endtask

  task automatic test_order();
    do_reset();
    apply(R, 6, 1'b0);
    apply(Y, 1, 1'b0);
    tests_run++;
    if (st !== 6'b10_0101 || cycle_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL order_r_to_y: st=%b cnt=%0d expected st=100101 cnt=0", st, cycle_count);
    end
  endtask

  task automatic test_onehot_resync();
    do_reset();
    apply(R, 2, 1'b0);
    apply(3'b101, 1, 1'b0);
    tests_run++;
    if (st !== 6'b11_1001) begin
      tests_failed++;
      $display("FAIL onehot_flag: st=%b expected 111001", st);
    end
    apply(G, 3, 1'b0);
    tests_run++;
    if (st !== 6'b11_1001) begin
      tests_failed++;
      $display("FAIL resync_hold: st=%b expected 111001", st);
    end
    apply(R, 1, 1'b0);
    tests_run++;
    if (st !== 6'b00_1001) begin
      tests_failed++;
      $display("FAIL resync_exit: st=%b expected 001001", st);
    end
    apply(R, 5, 1'b0);
    apply(G, 6, 1'b0);
    apply(Y, 3, 1'b0);
    apply(R, 1, 1'b0);
    tests_run++;
    if (st !== 6'b00_1001 || cycle_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL resync_count: st=%b cnt=%0d expected st=001001 cnt=1", st, cycle_count);
    end
  endtask

  // Continues from the post-resync state: red phase, dwell 1, count 1, err_onehot set.
  task automatic test_clear();
    apply(R, 1, 1'b1);
    tests_run++;
    if (st !== 6'b00_0000 || cycle_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL clear_alone: st=%b cnt=%0d expected st=000000 cnt=0", st, cycle_count);
    end
    apply(R, 4, 1'b0);
    tests_run++;
    if (st !== 6'b00_0000) begin
      tests_failed++;
      $display("FAIL clear_pre_overrun: st=%b expected 000000", st);
    end
    apply(R, 1, 1'b1);
    tests_run++;
    if (st !== 6'b00_0011) begin
      tests_failed++;
      $display("FAIL clear_set_wins: st=%b expected 000011", st);
    end
  endtask

  task automatic test_short_red();
    do_reset();
    apply(R, 5, 1'b0);
    apply(G, 1, 1'b0);
    tests_run++;
    if (st !== 6'b01_0011) begin
      tests_failed++;
      $display("FAIL short_red: st=%b expected 010011", st);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      apply(R, 6, 1'b0);
      apply(G, 6, 1'b0);
      apply(Y, 3, 1'b0);
    end
    apply(R, 1, 1'b0);
    tests_run++;
    if (cycle_count2 !== 2'd3 || st2 !== 6'b00_0000) begin
      tests_failed++;
      $display("FAIL count_saturate: cnt=%0d st=%b expected cnt=3 st=000000", cycle_count2, st2);
    end
    tests_run++;
    if (cycle_count !== 8'd5) begin
      tests_failed++;
      $display("FAIL count_wide: cnt=%0d expected 5", cycle_count);
    end
  endtask

  task automatic test_reset_mid_green();
    apply(R, 5, 1'b0);
    apply(G, 3, 1'b0);
    tests_run++;
    if (st !== 6'b01_0000 || cycle_count !== 8'd5) begin
      tests_failed++;
      $display("FAIL mid_green_pre: st=%b cnt=%0d expected st=010000 cnt=5", st, cycle_count);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (st !== 6'b00_0000 || cycle_count !== 8'd0 || cycle_count2 !== 2'd0) begin
      tests_failed++;
      $display("FAIL async_reset: st=%b cnt=%0d cnt2=%0d expected all zero", st, cycle_count, cycle_count2);
    end
    #1;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_cycles();
    test_overrun();
    test_order();
    test_onehot_resync();
    test_clear();
    test_short_red();
    test_saturation();
    test_reset_mid_green();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
